bios_wd_sequencer: RTL
======================

# bios_wd_sequencer

BIOS boot watchdog and failover sequencer for the dual-SPI-BIOS board. It arms when the main power rails come up and counts 125 ms strobes until BIOS writes a POST-complete code to a CPLD register. On expiry it issues a ForceSwap pulse and requests a power cycle so the board restarts from the other flash. It stops with a latched boot-fail indication after a configured number of consecutive failed attempts. It sits beside the BIOS chip-select logic, drives that logic's ForceSwap input, and shares the LPC register write bus.

## Interface
- TIMEOUT_TICKS, 240: 125 ms strobes allowed from arm to POST-complete (30 s); legal range 1..255.
- MAX_RETRY, 2: consecutive watchdog swaps allowed before the sequencer stops in FAIL; legal range 1..7.
- CYCLE_TICKS, 16: minimum power-off dwell, in strobes, while PowerCycleReq is held.

Ports:
- LpcClock  in  1  33 MHz LPC clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- ALL_PWRGD  in  1  main rails good; already synchronous to LpcClock.
- Strobe125ms  in  1  one-cycle tick every 125 ms, in the LpcClock domain.
- Write  in  1  one-cycle CPLD register write strobe.
- RegAddress  in  5  register address for the write.
- Data  in  8  write data.
- ForceSwap  out  2  one-cycle pulse: bit0 = watchdog swap, bit1 = manual swap.
- PowerCycleReq  out  1  request to the power sequencer to drop the rails.
- BootFail  out  1  latched; retry limit exhausted.
- WdStatus  out  8  {BootFail, RetryCnt[2:0], State[2:0], Armed}.

## Operation
- The register at 5'h5 is write-only.
  - Data 8'h55 = POST complete (kick).
  - Data 8'hA5 = manual swap request.
  - Data 8'h00 = disarm.
  - Any other value is ignored.
- States and transitions:
  - IDLE: waits for ALL_PWRGD=1, then clears TickCnt and goes to ARMED.
  - ARMED: a Strobe125ms increments TickCnt.
    - Kick → DONE and RetryCnt←0.
    - Disarm → DONE; RetryCnt is kept.
    - TickCnt reaches TIMEOUT_TICKS → EXPIRE.
    - ALL_PWRGD=0 → IDLE; TickCnt is cleared and RetryCnt is kept.
  - EXPIRE (one cycle):
    - If RetryCnt==MAX_RETRY → FAIL.
    - Otherwise ForceSwap=2'b01, RetryCnt+1, → CYCLE.
  - CYCLE: PowerCycleReq=1 until ALL_PWRGD is seen low and then CYCLE_TICKS strobes have elapsed; then PowerCycleReq=0 → IDLE.
  - DONE: holds until ALL_PWRGD falls → IDLE. Kicks are ignored.
  - FAIL: BootFail=1 and PowerCycleReq=0. Only Reset exits this state.
- Manual swap write (8'hA5) in any state except FAIL:
  - ForceSwap=2'b10 for one cycle.
  - No state change and no RetryCnt change.
- TickCnt is 8 bits and saturates at 255; it never wraps.
- RetryCnt is 3 bits and saturates at MAX_RETRY.
- Simultaneous kick and timeout in the same cycle: the kick wins and the state goes to DONE.
- A register write and a Strobe125ms in the same cycle: the write takes effect, and the tick also counts if the state stays ARMED.
- State encoding: IDLE=0, ARMED=1, EXPIRE=2, CYCLE=3, DONE=4, FAIL=5.

## Timing
- Reset values:
  - State=IDLE
  - TickCnt=0
  - RetryCnt=0
  - ForceSwap=2'b00
  - PowerCycleReq=0
  - BootFail=0
  - WdStatus=8'h00
- All outputs are registered.
- Kick write at cycle N: State=DONE is visible at N+1.
- Timeout on the strobe at cycle N: EXPIRE at N+1; ForceSwap pulse and PowerCycleReq rise at N+2.
- ForceSwap is exactly one LpcClock wide. It never stays asserted for back-to-back cycles from the same source.
- ALL_PWRGD rise at cycle N while in IDLE: ARMED at N+1. The first strobe counts from N+1.
- Reset asserted mid-CYCLE: PowerCycleReq drops the next cycle and all counters clear.

## Configuration
- BIOS_WD_STATUS_READ_EN defined: WdStatus is driven as listed under Interface.
- Not defined:
  - WdStatus is tied to 8'h00.
  - The status capture register is removed.
  - Sequencing behaviour is identical either way.

## Test plan
- Normal boot with TIMEOUT_TICKS=4: ALL_PWRGD=1, two strobes, write 8'h55 to 5'h5 → State=DONE, no ForceSwap, RetryCnt=0.
- Timeout with TIMEOUT_TICKS=4, no kick, four strobes → ForceSwap=2'b01 for one cycle, PowerCycleReq=1.
  - Then drop ALL_PWRGD and apply CYCLE_TICKS strobes → PowerCycleReq=0, State=IDLE, RetryCnt=1.
- Retry exhaustion with MAX_RETRY=2: three consecutive timeouts.
  - Two swap pulses, then BootFail=1 and no third pulse.
  - FAIL holds through later power cycles until Reset.
- Collision: kick write in the same cycle as the strobe that reaches TIMEOUT_TICKS → DONE, ForceSwap stays 2'b00.
- Manual swap: write 8'hA5 while ARMED → ForceSwap=2'b10 for one cycle, TickCnt unchanged, State=ARMED.
  - Write 8'h33 → no effect.
- Reset mid-CYCLE → next cycle PowerCycleReq=0, RetryCnt=0, WdStatus=8'h00.
  - With the macro defined, the WdStatus fields match State/RetryCnt after each step.

Source files
------------

// File: rtl/bios_wd_sequencer.sv
// BIOS boot watchdog / dual-flash failover sequencer on the LPC clock.
// Optional status capture register: define BIOS_WD_STATUS_READ_EN.
module bios_wd_sequencer #(
  parameter int TIMEOUT_TICKS = 240,
  parameter int MAX_RETRY     = 2,
  parameter int CYCLE_TICKS   = 16
) (
  input  logic       LpcClock,
  input  logic       Reset,
  input  logic       ALL_PWRGD,
  input  logic       Strobe125ms,
  input  logic       Write,
  input  logic [4:0] RegAddress,
  input  logic [7:0] Data,
  output logic [1:0] ForceSwap,
  output logic       PowerCycleReq,
  output logic       BootFail,
  output logic [7:0] WdStatus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARMED  = 3'd1;
  localparam logic [2:0] EXPIRE = 3'd2;
  localparam logic [2:0] CYCLE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;
  localparam logic [2:0] FAIL   = 3'd5;

  localparam logic [7:0] TIMEOUT   = 8'(TIMEOUT_TICKS);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);
  localparam logic [7:0] DWELL     = 8'(CYCLE_TICKS);

  logic [2:0] state, state_d;
  logic [7:0] tick_cnt, tick_d;
  logic [2:0] retry_cnt, retry_d;
  logic       seen_low, seen_low_d;
  logic [1:0] fs_d;
  logic       pcr_d, bf_d;

  logic reg_wr, kick, manual, disarm;
  logic [7:0] tick_inc;

  assign reg_wr   = Write && (RegAddress == 5'h05);
  assign kick     = reg_wr && (Data == 8'h55);
  assign manual   = reg_wr && (Data == 8'hA5);
  assign disarm   = reg_wr && (Data == 8'h00);
  assign tick_inc = (tick_cnt == 8'hFF) ? tick_cnt : tick_cnt + 8'd1;

  always_ff @(posedge LpcClock) begin
    if (Reset) begin
      state     <= IDLE;
      tick_cnt  <= 8'd0;
      retry_cnt <= 3'd0;
      seen_low  <= 1'b0;
    end else begin
      state     <= state_d;
      tick_cnt  <= tick_d;
      retry_cnt <= retry_d;
      seen_low  <= seen_low_d;
    end
  end

  always_comb begin
    state_d    = state;
    tick_d     = tick_cnt;
    retry_d    = retry_cnt;
    seen_low_d = seen_low;
    case (state)
      IDLE: if (ALL_PWRGD) begin
        state_d = ARMED;
        tick_d  = 8'd0;
      end
      ARMED: begin
        // Kick beats a coinciding timeout strobe.
        if (kick) begin
          state_d = DONE;
          retry_d = 3'd0;
        end else if (disarm) begin
          state_d = DONE;
        end else if (Strobe125ms && tick_inc >= TIMEOUT) begin
          state_d = EXPIRE;
          tick_d  = tick_inc;
        end else if (!ALL_PWRGD) begin
          state_d = IDLE;
          tick_d  = 8'd0;
        end else if (Strobe125ms) begin
          tick_d  = tick_inc;
        end
      end
      EXPIRE: begin
        if (retry_cnt >= RETRY_MAX) begin
          state_d = FAIL;
        end else begin
          state_d    = CYCLE;
          retry_d    = retry_cnt + 3'd1;
          tick_d     = 8'd0;
          seen_low_d = 1'b0;
        end
      end
      CYCLE: begin
        // Dwell only starts counting once the rails are observed down.
        if (!ALL_PWRGD) seen_low_d = 1'b1;
        if (seen_low && Strobe125ms) begin
          if (tick_inc >= DWELL) begin
            state_d = IDLE;
            tick_d  = 8'd0;
          end else begin
            tick_d  = tick_inc;
          end
        end
      end
      DONE: if (!ALL_PWRGD) state_d = IDLE;
      FAIL: state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fs_d    = 2'b00;
    fs_d[0] = (state == EXPIRE) && (retry_cnt < RETRY_MAX);
    fs_d[1] = manual && (state != FAIL) && !ForceSwap[1];
    pcr_d   = (state_d == CYCLE);
    bf_d    = (state_d == FAIL);
  end

  always_ff @(posedge LpcClock) begin
    if (Reset) begin
      ForceSwap     <= 2'b00;
      PowerCycleReq <= 1'b0;
      BootFail      <= 1'b0;
    end else begin
      ForceSwap     <= fs_d;
      PowerCycleReq <= pcr_d;
      BootFail      <= bf_d;
    end
  end

`ifdef BIOS_WD_STATUS_READ_EN
  logic [7:0] status_q;
  // Captured from next-state values so fields line up with the live state.
  always_ff @(posedge LpcClock) begin
    if (Reset) status_q <= 8'h00;
    else       status_q <= {bf_d, retry_d, state_d, state_d == ARMED};
  end
  assign WdStatus = status_q;
`else
  assign WdStatus = 8'h00;
`endif

endmodule
